// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cla_pkg
//  Purpose  : Shared types and elaboration helpers for the pipelined
//             carry-lookahead adder/subtractor (param_cla_pipe, cla_slice).
//  Revision : 1.0  initial release
// ============================================================================
package cla_pkg;

    // Operation selected by the sub input
    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Bits resolved by each pipeline stage
    function automatic int calc_slice(input int width, input int stages);
        return (stages > 0) ? (width / stages) : width;
    endfunction

    // True when the width splits evenly into stages and each slice into groups
    function automatic bit cfg_ok(input int width, input int stages, input int block);
        if ((width <= 0) || (stages <= 0) || (block <= 0)) begin
            return 1'b0;
        end
        if ((width % stages) != 0) begin
            return 1'b0;
        end
        return (((width / stages) % block) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cla_slice.sv
`default_nettype none
// ============================================================================
//  Module   : cla_slice
//  Purpose  : Combinational SLICE-bit carry-lookahead adder built from
//             BLOCK-bit generate/propagate groups with group lookahead.
//             Also exports the carry into the MSB for overflow detection.
//  Revision : 1.0  initial release
// ============================================================================
module cla_slice #(
    parameter int SLICE = 4,
    parameter int BLOCK = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout,
    output logic             c_msb
);
    import cla_pkg::*;

    localparam int NGRP = SLICE / BLOCK;

    if (!cfg_ok(SLICE, 1, BLOCK)) begin : g_cfg_err
        $fatal(1, "cla_slice: SLICE must be a positive multiple of BLOCK");
    end

    logic [SLICE-1:0] w_g;
    logic [SLICE-1:0] w_p;
    logic [SLICE-1:0] w_c;
    logic [NGRP-1:0]  w_gg;
    logic [NGRP-1:0]  w_gp;
    logic [NGRP:0]    w_cg;
    logic             w_acc;
    logic             w_bc;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Group generate / propagate for every BLOCK-bit group
    always_comb begin
        w_gg = '0;
        w_gp = '1;
        for (int j = 0; j < NGRP; j++) begin
            for (int i = 0; i < BLOCK; i++) begin
                w_gg[j] = w_g[j*BLOCK+i] | (w_p[j*BLOCK+i] & w_gg[j]);
                w_gp[j] = w_gp[j] & w_p[j*BLOCK+i];
            end
        end
    end

    // Group lookahead: each group carry is an independent cone from cin
    always_comb begin
        w_cg    = '0;
        w_acc   = 1'b0;
        w_cg[0] = cin;
        for (int j = 0; j < NGRP; j++) begin
            w_acc = cin;
            for (int m = 0; m <= j; m++) begin
                w_acc = w_gg[m] | (w_gp[m] & w_acc);
            end
            w_cg[j+1] = w_acc;
        end
    end

    // Bit carries inside each group, seeded by that group's carry-in
    always_comb begin
        w_c  = '0;
        w_bc = 1'b0;
        for (int j = 0; j < NGRP; j++) begin
            w_bc = w_cg[j];
            for (int i = 0; i < BLOCK; i++) begin
                w_c[j*BLOCK+i] = w_bc;
                w_bc = w_g[j*BLOCK+i] | (w_p[j*BLOCK+i] & w_bc);
            end
        end
    end

    assign sum   = w_p ^ w_c;
    assign cout  = w_cg[NGRP];
    assign c_msb = w_c[SLICE-1];

endmodule
`default_nettype wire

// File: rtl/param_cla_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : param_cla_pipe
//  Purpose  : Pipelined WIDTH2-bit carry-lookahead adder/subtractor. Each of
//             the STAGES stages resolves one SLICE of the operation and hands
//             the running carry and the unprocessed operand bits onward.
//             Valid/ready handshake with backpressure; carry, overflow and
//             zero flags registered with the result.
//  Revision : 1.0  initial release
// ============================================================================
module param_cla_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH2 = 8,
    parameter int STAGES = 2,
    parameter int BLOCK  = 4
) (
    input  logic              clk_pi,
    input  logic              rst_pi,
    input  logic [WIDTH2-1:0] A_pi,
    input  logic [WIDTH2-1:0] B_pi,
    input  logic              cin_pi,
    input  logic              sub_pi,
    input  logic              in_valid_pi,
    output logic              in_ready_po,
    output logic [WIDTH2-1:0] result_po,
    output logic              cout_po,
    output logic              ovf_po,
    output logic              zero_po,
    output logic              out_valid_po,
    input  logic              out_ready_pi
);

    localparam int SLICE = calc_slice(WIDTH2, STAGES);
    localparam int LAST  = STAGES - 1;
    localparam int REM_W = (STAGES > 1) ? (WIDTH2 - SLICE) : SLICE;
    localparam int MID_N = (STAGES > 1) ? (STAGES - 1) : 1;

    if (!cfg_ok(WIDTH2, STAGES, BLOCK)) begin : g_cfg_err
        $fatal(1, "param_cla_pipe: WIDTH2 %% STAGES and SLICE %% BLOCK must both be 0");
    end

    // Stage record for the intermediate stages; its valid bit is kept in
    // r_valid so that only the valid bits carry the asynchronous reset.
    typedef struct packed {
        logic [WIDTH2-1:0] res;    // partial result, low (k+1)*SLICE bits meaningful
        logic              carry;  // carry out of the slice resolved so far
        logic [REM_W-1:0]  a;      // operand A bits not yet summed
        logic [REM_W-1:0]  b;      // operand B bits (already inverted for sub)
    } stage_t;

    op_e               w_op;
    logic              w_cin_eff;
    logic [WIDTH2-1:0] w_b_eff;

    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] w_load;
    logic [STAGES-1:0] w_valid_in;
    stage_t            r_stage [MID_N];

    logic [SLICE-1:0]  w_sl_a    [STAGES];
    logic [SLICE-1:0]  w_sl_b    [STAGES];
    logic [SLICE-1:0]  w_sl_sum  [STAGES];
    logic              w_sl_cin  [STAGES];
    logic              w_sl_cout [STAGES];
    logic              w_sl_cmsb [STAGES];
    logic [WIDTH2-1:0] w_res     [STAGES];

    logic [WIDTH2-1:0] r_result;
    logic              r_cout;
    logic              r_ovf;
    logic              r_zero;

    assign w_op      = sub_pi ? OP_SUB : OP_ADD;
    assign w_cin_eff = (w_op == OP_SUB) ? 1'b1 : cin_pi;
    assign w_b_eff   = (w_op == OP_SUB) ? ~B_pi : B_pi;

    // Backward ready chain: a stage loads when empty or when its content moves on
    always_comb begin
        w_load       = '0;
        w_valid_in   = '0;
        w_load[LAST] = ~r_valid[LAST] | out_ready_pi;
        for (int k = LAST - 1; k >= 0; k--) begin
            w_load[k] = ~r_valid[k] | w_load[k+1];
        end
        w_valid_in[0] = in_valid_pi;
        for (int k = 1; k < STAGES; k++) begin
            w_valid_in[k] = r_valid[k-1];
        end
    end

    // Stage valid bits; cleared at once by reset so nothing in flight survives
    always_ff @(posedge clk_pi or posedge rst_pi) begin
        if (rst_pi) begin
            r_valid <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_load[k]) begin
                    r_valid[k] <= w_valid_in[k];
                end
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign w_sl_a[k]   = A_pi[SLICE-1:0];
            assign w_sl_b[k]   = w_b_eff[SLICE-1:0];
            assign w_sl_cin[k] = w_cin_eff;
            assign w_res[k]    = WIDTH2'(w_sl_sum[k]);
        end else begin : g_body
            assign w_sl_a[k]   = r_stage[k-1].a[SLICE-1:0];
            assign w_sl_b[k]   = r_stage[k-1].b[SLICE-1:0];
            assign w_sl_cin[k] = r_stage[k-1].carry;
            assign w_res[k]    = r_stage[k-1].res | (WIDTH2'(w_sl_sum[k]) << (k * SLICE));
        end

        cla_slice #(
            .SLICE (SLICE),
            .BLOCK (BLOCK)
        ) u_slice (
            .a     (w_sl_a[k]),
            .b     (w_sl_b[k]),
            .cin   (w_sl_cin[k]),
            .sum   (w_sl_sum[k]),
            .cout  (w_sl_cout[k]),
            .c_msb (w_sl_cmsb[k])
        );

        if (k < LAST) begin : g_mid
            logic [REM_W-1:0] w_a_rem;
            logic [REM_W-1:0] w_b_rem;

            if (k == 0) begin : g_from_port
                assign w_a_rem = A_pi[WIDTH2-1:SLICE];
                assign w_b_rem = w_b_eff[WIDTH2-1:SLICE];
            end else begin : g_from_stage
                assign w_a_rem = r_stage[k-1].a >> SLICE;
                assign w_b_rem = r_stage[k-1].b >> SLICE;
            end

            // Intermediate data only captured when a valid operation moves in
            always_ff @(posedge clk_pi) begin
                if (w_load[k] && w_valid_in[k]) begin
                    r_stage[k] <= '{res:   w_res[k],
                                    carry: w_sl_cout[k],
                                    a:     w_a_rem,
                                    b:     w_b_rem};
                end
            end
        end
    end

    // Output stage: final result and flags, held while downstream stalls
    always_ff @(posedge clk_pi or posedge rst_pi) begin
        if (rst_pi) begin
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else if (w_load[LAST] && w_valid_in[LAST]) begin
            r_result <= w_res[LAST];
            r_cout   <= w_sl_cout[LAST];
            r_ovf    <= w_sl_cout[LAST] ^ w_sl_cmsb[LAST];
            r_zero   <= (w_res[LAST] == '0);
        end
    end

    assign in_ready_po  = w_load[0];
    assign out_valid_po = r_valid[LAST];
    assign result_po    = r_result;
    assign cout_po      = r_cout;
    assign ovf_po       = r_ovf;
    assign zero_po      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_param_cla_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_param_cla_pipe
//  Purpose  : Directed self-checking bench for param_cla_pipe
//             (WIDTH2=8, STAGES=2, BLOCK=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_param_cla_pipe;

    localparam int W = 8;

    logic         clk       = 1'b0;
    logic         rst       = 1'b1;
    logic [W-1:0] a_in      = '0;
    logic [W-1:0] b_in      = '0;
    logic         cin       = 1'b0;
    logic         sub       = 1'b0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b1;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
    logic         zero;

    int checks   = 0;
    int failures = 0;
    int tx;
    int rx;
    logic acc;

    logic [7:0]  sa [10];
    logic [7:0]  sb [10];
    logic        sc [10];
    logic        ss [10];

    logic [7:0]  bp_a   [6];
    logic [7:0]  bp_b   [6];
    logic        bp_c   [6];
    logic        bp_s   [6];
    logic [10:0] bp_exp [6];

    always #5 clk = ~clk;

    param_cla_pipe #(
        .WIDTH2 (W),
        .STAGES (2),
        .BLOCK  (4)
    ) dut (
        .clk_pi       (clk),
        .rst_pi       (rst),
        .A_pi         (a_in),
        .B_pi         (b_in),
        .cin_pi       (cin),
        .sub_pi       (sub),
        .in_valid_pi  (in_valid),
        .in_ready_po  (in_ready),
        .result_po    (result),
        .cout_po      (cout),
        .ovf_po       (ovf),
        .zero_po      (zero),
        .out_valid_po (out_valid),
        .out_ready_pi (out_ready)
    );

    // {zero, ovf, cout, result}
    function automatic logic [10:0] model(input logic [7:0] x, input logic [7:0] y,
                                          input logic ci, input logic s);
        logic [7:0] yy;
        logic       c0;
        logic [8:0] full;
        logic [7:0] low;
        yy   = s ? ~y : y;
        c0   = s ? 1'b1 : ci;
        full = {1'b0, x} + {1'b0, yy} + {8'b0, c0};
        low  = {1'b0, x[6:0]} + {1'b0, yy[6:0]} + {7'b0, c0};
        return {(full[7:0] == 8'h00), low[7] ^ full[8], full[8], full[7:0]};
    endfunction

    function automatic logic [10:0] obs();
        return {zero, ovf, cout, result};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] x, input logic [7:0] y,
                         input logic ci, input logic s, input logic v);
        a_in     = x;
        b_in     = y;
        cin      = ci;
        sub      = s;
        in_valid = v;
    endtask

    task automatic directed(input string tag, input logic [7:0] x, input logic [7:0] y,
                            input logic ci, input logic s, input logic [10:0] expv);
        drive(x, y, ci, s, 1'b1);
        tick();
        in_valid = 1'b0;
        chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
        tick();
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk(tag, 32'(obs()), 32'(expv));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bp_a   = '{8'h01, 8'h10, 8'h33, 8'hFF, 8'h7F, 8'h00};
        bp_b   = '{8'h02, 8'h20, 8'h11, 8'hFF, 8'h01, 8'h01};
        bp_c   = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0};
        bp_s   = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1};
        bp_exp = '{11'h003, 11'h030, 11'h122, 11'h1FF, 11'h280, 11'h0FF};

        // Reset state
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_outputs", 32'(obs()), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        #2 rst = 1'b0;
        tick();
        chk("idle_out_valid", 32'(out_valid), 32'd0);

        // Directed single operations
        directed("add_50_40", 8'h50, 8'h40, 1'b0, 1'b0, 11'h290);
        directed("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 11'h500);
        directed("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b1, 11'h0FE);
        directed("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 11'h37F);
        directed("add_0f_cin", 8'h0F, 8'h00, 1'b1, 1'b0, 11'h010);
        directed("sub_42_42", 8'h42, 8'h42, 1'b0, 1'b1, 11'h500);

        // Streaming, back-to-back with downstream always ready
        for (int i = 0; i < 10; i++) begin
            sa[i] = 8'($urandom_range(0, 255));
            sb[i] = 8'($urandom_range(0, 255));
            sc[i] = 1'($urandom_range(0, 1));
            ss[i] = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
        for (int t = 0; t < 12; t++) begin
            if (t < 10) begin
                drive(sa[t], sb[t], sc[t], ss[t], 1'b1);
                chk("stream_in_ready", 32'(in_ready), 32'd1);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            chk("stream_valid", 32'(out_valid), 32'((t >= 1) && (t <= 10)));
            if (out_valid && (t >= 1) && (t <= 10)) begin
                chk("stream_data", 32'(obs()), 32'(model(sa[t-1], sb[t-1], sc[t-1], ss[t-1])));
            end
        end

        // Backpressure: downstream stalled for five cycles
        tx = 0;
        rx = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            drive(bp_a[tx], bp_b[tx], bp_c[tx], bp_s[tx], 1'b1);
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'(c < 2));
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) tx++;
            chk("bp_out_valid", 32'(out_valid), 32'(c >= 1));
            if (c >= 1) chk("bp_hold", 32'(obs()), 32'(bp_exp[0]));
        end
        chk("bp_accepted", 32'(tx), 32'd2);
        out_ready = 1'b1;
        for (int cyc = 0; (cyc < 30) && (rx < 6); cyc++) begin
            if (tx < 6) drive(bp_a[tx], bp_b[tx], bp_c[tx], bp_s[tx], 1'b1);
            else        in_valid = 1'b0;
            #1;
            acc = in_ready && in_valid;
            if (out_valid) begin
                chk("bp_order", 32'(obs()), 32'(bp_exp[rx]));
                rx++;
            end
            @(posedge clk);
            #1;
            if (acc) tx++;
        end
        chk("bp_rx_count", 32'(rx), 32'd6);
        chk("bp_tx_count", 32'(tx), 32'd6);
        in_valid = 1'b0;
        tick();
        tick();
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Reset with two operations in flight
        out_ready = 1'b0;
        drive(8'h11, 8'h22, 1'b0, 1'b0, 1'b1);
        tick();
        drive(8'h33, 8'h44, 1'b0, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("mid_pre_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_result", 32'(result), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        tick();
        #2 rst = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("post_rst_idle1", 32'(out_valid), 32'd0);
        tick();
        chk("post_rst_idle2", 32'(out_valid), 32'd0);
        directed("post_rst_first", 8'h0A, 8'h05, 1'b0, 1'b0, 11'h00F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
